// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  // Width of the byte PC carried through the skid FIFO; fetch_stage's INST_SIZE
  // defaults to this and is expected to match it.
  localparam int PC_BITS    = 10;
  localparam int PC_STEP    = 4;
  localparam int FIFO_DEPTH = 2;

  typedef logic [PC_BITS-1:0] pc_t;
  typedef logic [31:0]        inst_t;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO of {inst, pc}. slot0 is always the head; a pop shifts
// slot1 forward. flush empties the FIFO after any same-cycle pop completes.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;

  // Occupancy and slot update; the caller never pushes into a full FIFO
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues sequential reads to a
// 1-cycle-latency instruction BRAM, takes redirects from the memory stage and
// hands {inst, pc} to decode through a 2-entry skid FIFO.
// Optional: FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect flag.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                   INST_SIZE = PC_BITS,
  parameter logic [INST_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 npc_we,
  input  logic [INST_SIZE-1:0] npc,
  output logic                 imem_en,
  output logic [INST_SIZE-3:0] imem_addr,
  input  logic [31:0]          imem_dout,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst,
  output logic [INST_SIZE-1:0] inst_pc,
  output logic                 misalign
);

  localparam logic [INST_SIZE-1:0] ALIGN_MASK = ~INST_SIZE'(3);

  logic [INST_SIZE-1:0] fetch_pc;
  logic [INST_SIZE-1:0] inflight_pc;
  logic [INST_SIZE-1:0] issued_pc;
  logic                 inflight;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic [1:0]           count;
  logic [2:0]           occupancy;
  fetch_entry_t         push_entry;
  fetch_entry_t         head;

  assign pop = inst_valid & inst_ready;

  // Words already owed a FIFO slot once this cycle's pop retires; a new read
  // is only safe while that leaves room for it.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = rstn & (npc_we | (occupancy < 3'(FIFO_DEPTH)));
  assign issued_pc = npc_we ? (npc & ALIGN_MASK) : fetch_pc;
  assign imem_en   = issue;
  assign imem_addr = issued_pc[INST_SIZE-1:2];

  // A word returning during a redirect belongs to the abandoned path
  assign push            = inflight & ~npc_we;
  assign push_entry.inst = imem_dout;
  assign push_entry.pc   = pc_t'(inflight_pc);

  // PC advance and in-flight read tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= issued_pc + INST_SIZE'(PC_STEP);
        inflight_pc <= issued_pc;
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (npc_we),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  assign inst_valid = (count != 2'd0);
  assign inst       = head.inst;
  assign inst_pc    = INST_SIZE'(head.pc);

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky flag for any redirect target that is not word-aligned
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             misalign <= 1'b0;
    else if (npc_we && (npc[1:0] != 2'b00)) misalign <= 1'b1;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int             IS    = 10;
  localparam logic [IS-1:0]  RPC   = '0;
  localparam logic [IS-1:0]  ALIGN = ~IS'(3);

  typedef struct packed {
    logic [31:0]   inst;
    logic [IS-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          npc_we = 1'b0;
  logic [IS-1:0] npc = '0;
  logic          imem_en;
  logic [IS-3:0] imem_addr;
  logic [31:0]   imem_dout = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst;
  logic [IS-1:0] inst_pc;
  logic          misalign;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            pops = 0;
  logic [31:0]   mem [0:(1<<(IS-2))-1];
  exp_t          sb[$];
  exp_t          mon_e;
  logic [IS-1:0] next_pc = RPC;
  logic          exp_mis = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.INST_SIZE(IS), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .npc_we     (npc_we),
    .npc        (npc),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_dout  (imem_dout),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .misalign   (misalign)
  );

  // Instruction BRAM with one cycle of read latency
  always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected program order: sequential PCs from the last restart point; a
  // redirect seen at an edge discards everything predicted and restarts at npc.
  task automatic tick();
    @(posedge clk);
    if (rstn && npc_we) begin
      sb.delete();
      next_pc = npc & ALIGN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (npc[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    end
    if (rstn) begin
      while (sb.size() < 4) begin
        sb.push_back('{inst: mem[next_pc[IS-1:2]], pc: next_pc});
        next_pc = next_pc + IS'(4);
      end
    end
    #1;
  endtask

  task automatic redirect(input logic [IS-1:0] tgt, input logic rdy);
    npc_we = 1'b1;
    npc = tgt;
    inst_ready = rdy;
    #1;
    chk("redir_imem_en", 32'(imem_en), 32'd1);
    chk("redir_imem_addr", 32'(imem_addr), 32'(tgt[IS-1:2]));
    tick();
    npc_we = 1'b0;
  endtask

  // Monitor: every handshake must deliver the oldest predicted {inst, pc}
  always @(negedge clk) begin
    if (rstn) begin
      chk("misalign", 32'(misalign), 32'(exp_mis));
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_underflow: got pc %h, expected no delivery", inst_pc);
        end else begin
          mon_e = sb.pop_front();
          chk("deliver_pc", 32'(inst_pc), 32'(mon_e.pc));
          chk("deliver_inst", inst, mon_e.inst);
          pops++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [IS-1:0] prev_pc;
    logic          prev_v;
    logic [IS-3:0] prev_addr;
    logic          prev_en;
    logic          wrap_pc_seen;
    logic          wrap_addr_seen;
    int            idle;
    int            pops0;

    for (int i = 0; i < (1 << (IS-2)); i++) mem[i] = 32'h1000_0000 + i;

    // reset state
    inst_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", 32'(inst_pc), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    rstn = 1'b1;

    // first instruction valid only after the 2nd edge, then back-to-back
    tick();
    chk("first_e1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("first_e2_valid", 32'(inst_valid), 32'd1);
    chk("first_e2_pc", 32'(inst_pc), 32'h000);
    chk("first_e2_inst", inst, 32'h1000_0000);
    tick();
    chk("seq_pc4", 32'(inst_pc), 32'h004);
    chk("seq_inst1", inst, 32'h1000_0001);
    tick();
    chk("seq_pc8", 32'(inst_pc), 32'h008);

    // decode stall: reads stop once the FIFO plus in-flight word fill it
    inst_ready = 1'b0;
    #1;
    chk("stall_en_drop", 32'(imem_en), 32'd0);
    repeat (5) tick();
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_en_low", 32'(imem_en), 32'd0);
    chk("stall_head_pc", 32'(inst_pc), 32'h008);
    inst_ready = 1'b1;
    repeat (6) tick();

    // redirect while full
    inst_ready = 1'b0;
    repeat (3) tick();
    redirect(IS'(10'h040), 1'b0);
    chk("redir_full_flush", 32'(inst_valid), 32'd0);
    tick();
    chk("redir_full_valid", 32'(inst_valid), 32'd1);
    chk("redir_full_pc", 32'(inst_pc), 32'h040);
    inst_ready = 1'b1;
    tick();
    chk("redir_full_next", 32'(inst_pc), 32'h044);

    // redirect coincident with the pop of pc 0x010
    redirect(IS'(10'h010), 1'b1);
    tick();
    chk("coinc_head", 32'(inst_pc), 32'h010);
    redirect(IS'(10'h100), 1'b1);
    chk("coinc_flush", 32'(inst_valid), 32'd0);
    tick();
    chk("coinc_target", 32'(inst_pc), 32'h100);

    // PC wrap across 0x3FC
    redirect(IS'(10'h3F0), 1'b1);
    prev_v = 1'b0; prev_pc = '0; prev_en = 1'b0; prev_addr = '0;
    wrap_pc_seen = 1'b0; wrap_addr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (prev_en && prev_addr == '1) begin
        chk("wrap_imem_addr", 32'(imem_addr), 32'd0);
        wrap_addr_seen = 1'b1;
      end
      if (prev_v && prev_pc == IS'(10'h3FC)) begin
        chk("wrap_inst_pc", 32'(inst_pc), 32'h000);
        wrap_pc_seen = 1'b1;
      end
      prev_v = inst_valid; prev_pc = inst_pc;
      prev_en = imem_en;   prev_addr = imem_addr;
      tick();
    end
    chk("wrap_pc_reached", 32'(wrap_pc_seen), 32'd1);
    chk("wrap_addr_reached", 32'(wrap_addr_seen), 32'd1);

    // reset mid-stall with two entries buffered
    inst_ready = 1'b0;
    repeat (3) tick();
    chk("prerst_valid", 32'(inst_valid), 32'd1);
    rstn = 1'b0;
    sb.delete();
    next_pc = RPC;
    exp_mis = 1'b0;
    #1;
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_imem_en", 32'(imem_en), 32'd0);
    chk("midrst_inst", inst, 32'd0);
    chk("midrst_pc", 32'(inst_pc), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk("restart_e1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("restart_valid", 32'(inst_valid), 32'd1);
    chk("restart_pc", 32'(inst_pc), 32'(RPC));

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect(IS'(10'h042), 1'b1);
    chk("mis_set", 32'(misalign), 32'd1);
    tick();
    chk("mis_aligned_pc", 32'(inst_pc), 32'h040);
`endif

    // randomized ready/redirect traffic
    idle = 0;
    pops0 = pops;
    for (int i = 0; i < 400; i++) begin
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        npc_we = 1'b1;
        npc = IS'($urandom);
      end else begin
        npc_we = 1'b0;
      end
      tick();
      if (inst_valid) idle = 0;
      else idle++;
      if (idle > 6) begin
        chk("liveness_valid", 32'(inst_valid), 32'd1);
        idle = 0;
      end
    end
    npc_we = 1'b0;
    inst_ready = 1'b1;
    repeat (4) tick();
    chk("rand_progress", 32'(pops - pops0 > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined CPU.
- Owns the architectural PC and issues sequential reads to the instruction BRAM, which has 1-cycle read latency.
- Accepts redirects (npc) from the memory stage when a branch, jump or jr resolves.
- Delivers instruction/PC pairs to decode through a valid/ready handshake, with a 2-entry skid FIFO so no fetched word is lost while decode stalls.

Parameters:
- INST_SIZE, 10, PC width in bits; byte address; instruction BRAM holds 2^(INST_SIZE-2) words.
- RESET_PC, 0, PC value loaded on reset (INST_SIZE bits, word-aligned).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous assert, active-low.
- npc_we  input  1  memory stage requests redirect this cycle.
- npc  input  INST_SIZE  redirect target (byte address).
- imem_en  output  1  instruction BRAM read enable (combinational).
- imem_addr  output  INST_SIZE-2  BRAM word address (combinational).
- imem_dout  input  32  BRAM read data, valid the cycle after imem_en.
- inst_valid  output  1  head of FIFO valid.
- inst_ready  input  1  decode accepts head.
- inst  output  32  instruction word at head.
- inst_pc  output  INST_SIZE  byte PC of head instruction.
- misalign  output  1  sticky misaligned-redirect flag (MISALIGN_TRAP_EN only; tied 0 otherwise).

Behaviour:
- Clock and reset: single clock clk. rstn is asynchronous, active-low.
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty (count = 0).
  - inflight = 0.
  - inst_valid = 0, inst = 0, inst_pc = 0.
  - imem_en = 0 while rstn is low.
  - misalign = 0.
- State:
  - fetch_pc: next PC to request.
  - inflight: a read was issued last cycle.
  - inflight_pc.
  - FIFO of {inst, pc}, depth 2.
- pop = inst_valid & inst_ready.
- Issue rule:
  - issue = rstn & (npc_we | (count + inflight - pop < 2)).
  - imem_en = issue.
  - imem_addr = (npc_we ? npc : fetch_pc)[INST_SIZE-1:2].
- On each issue edge:
  - fetch_pc <= issued_pc + 4, modulo 2^INST_SIZE (0x3FC wraps to 0x000).
  - inflight <= 1.
  - inflight_pc <= issued_pc.
  - With no issue, inflight <= 0.
- Capture: if inflight and no redirect this cycle, push {imem_dout, inflight_pc} into the FIFO.
- Ordering and occupancy:
  - Push and pop may occur in the same cycle.
  - The issue rule guarantees the FIFO never overflows.
  - Output is strictly in program order.
- Redirect (npc_we = 1):
  - The pop in that cycle completes normally.
  - All remaining FIFO entries and the in-flight word are discarded.
  - npc is issued in the same cycle and fetch_pc <= npc + 4.
  - A redirect during an active redirect's latency simply re-flushes.
- Latencies:
  - The first instruction after reset release has inst_valid high after the 2nd rising edge.
  - Redirect at edge E: target instruction has inst_valid high after edge E+1 (2-edge redirect penalty).
- Alignment: npc[1:0] is ignored for addressing, and inst_pc reports it cleared.
- Reset mid-operation: immediate return to reset values; any in-flight data is dropped.
- Decode contract: decode must not depend on inst/inst_pc while inst_valid = 0.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with npc[1:0] != 0 sets misalign; it stays set until reset.
  - The fetch still proceeds from the aligned address.
- Undefined: misalign is tied 0, and no extra flops are inferred.

Decomposition:
- Package fetch_pkg:
  - pc_t (logic [INST_SIZE-1:0]).
  - inst_t (logic [31:0]).
  - fetch_entry_t struct {inst_t inst; pc_t pc}.
  - PC_STEP = 4.
  - FIFO_DEPTH = 2.
- Sub-module fetch_skid_fifo:
  - 2-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, count, head.
  - Instantiated once.

Test Plan:
- Reset, inst_ready=1, BRAM word n = 0x1000_0000+n -> inst_valid after 2nd edge; pairs (0x10000000,0x000), (0x10000001,0x004), (0x10000002,0x008) on consecutive cycles.
- inst_ready=0 for 5 cycles after first valid -> imem_en drops once count+inflight=2; on release the sequence continues 0x000, 0x004, 0x008 with no gap or duplicate.
- FIFO full, npc_we=1 with npc=0x040 -> old entries vanish; next accepted inst_pc=0x040 two edges later, then 0x044.
- npc_we coincident with pop of pc 0x010 -> 0x010 is delivered once; the next delivered pc is npc.
- Continuous fetch across 0x3FC -> next inst_pc=0x000, imem_addr=0.
- rstn pulsed low mid-stall with 2 entries buffered -> inst_valid=0 immediately and restart at RESET_PC. With FETCH_MISALIGN_TRAP_EN, npc=0x042 -> misalign=1 and inst_pc=0x040.
